// File: rtl/rf_pkg.sv
// Shared widths, on/off levels, requester FSM encoding and the latched command record.
package rf_pkg;
   localparam int REG_SIZE   = 32;
   localparam int INDEX_SIZE = 5;
   localparam int TIMER_W    = 8;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   typedef struct packed {
      logic [INDEX_SIZE-1:0] rs;
      logic [INDEX_SIZE-1:0] rt;
      logic [INDEX_SIZE-1:0] wr_addr;
      logic                  wr_en;
      logic [REG_SIZE-1:0]   wr_data;
   } cmd_t;
endpackage

// File: rtl/rf_32_requester_if.sv
// Command, register-file and response signals of the requester; master is the requester itself.
interface rf_32_requester_if;
   import rf_pkg::*;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [INDEX_SIZE-1:0] cmd_rs;
   logic [INDEX_SIZE-1:0] cmd_rt;
   logic [INDEX_SIZE-1:0] cmd_wr_addr;
   logic                  cmd_wr_en;
   logic [REG_SIZE-1:0]   cmd_wr_data;

   logic                  start;
   logic [INDEX_SIZE-1:0] read_addr_s;
   logic [INDEX_SIZE-1:0] read_addr_t;
   logic [INDEX_SIZE-1:0] write_addr;
   logic                  write_enabled;
   logic [REG_SIZE-1:0]   write_data;
   logic                  finish;
   logic [REG_SIZE-1:0]   outA;
   logic [REG_SIZE-1:0]   outB;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [REG_SIZE-1:0]   rsp_a;
   logic [REG_SIZE-1:0]   rsp_b;
   logic                  rsp_err;

   modport master (
      input  cmd_valid, cmd_rs, cmd_rt, cmd_wr_addr, cmd_wr_en, cmd_wr_data,
      output cmd_ready,
      output start, read_addr_s, read_addr_t, write_addr, write_enabled, write_data,
      input  finish, outA, outB,
      output rsp_valid, rsp_a, rsp_b, rsp_err,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_rs, cmd_rt, cmd_wr_addr, cmd_wr_en, cmd_wr_data,
      input  cmd_ready,
      input  start, read_addr_s, read_addr_t, write_addr, write_enabled, write_data,
      output finish, outA, outB,
      input  rsp_valid, rsp_a, rsp_b, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/rf_req_timer.sv
// Shared strobe/timeout down-counter: load wins over decrement, holds at zero.
module rf_req_timer
   import rf_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   input  logic               dec_i,
   output logic               zero_o
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/rf_32_requester.sv
// Single-outstanding requester: latches a command, strobes the register file, returns read data or a timeout.
//
// state     | meaning
// ST_IDLE   | ready for a command
// ST_SETUP  | fields on register-file ports, start low, one cycle
// ST_STROBE | start high for STROBE_CYCLES cycles
// ST_WAIT   | waiting for finish, abandoned after TIMEOUT_CYCLES
// ST_RESP   | response held until rsp_ready
module rf_32_requester
   import rf_pkg::*;
#(
   parameter int STROBE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic                clk,
   input logic                reset,
   rf_32_requester_if.master  bus
);

   localparam logic [TIMER_W-1:0] STROBE_LOAD  = TIMER_W'(STROBE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

   state_t              state_q, state_d;
   cmd_t                cmd_q, cmd_d;
   logic [REG_SIZE-1:0] rsp_a_q, rsp_a_d;
   logic [REG_SIZE-1:0] rsp_b_q, rsp_b_d;
   logic                rsp_err_q, rsp_err_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_dec;
   logic               tmr_zero;
   logic               busy;

   rf_req_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      rsp_a_d   = rsp_a_q;
      rsp_b_d   = rsp_b_q;
      rsp_err_d = rsp_err_q;
      tmr_load  = OFF;
      tmr_val   = STROBE_LOAD;
      tmr_dec   = OFF;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               cmd_d.rs      = bus.cmd_rs;
               cmd_d.rt      = bus.cmd_rt;
               cmd_d.wr_addr = bus.cmd_wr_addr;
               cmd_d.wr_en   = bus.cmd_wr_en;
               cmd_d.wr_data = bus.cmd_wr_data;
               state_d       = ST_SETUP;
            end
         end
         ST_SETUP: begin
            tmr_load = ON;
            tmr_val  = STROBE_LOAD;
            state_d  = ST_STROBE;
         end
         ST_STROBE: begin
            if (tmr_zero) begin
               tmr_load = ON;
               tmr_val  = TIMEOUT_LOAD;
               state_d  = ST_WAIT;
            end else begin
               tmr_dec = ON;
            end
         end
         ST_WAIT: begin
            if (bus.finish) begin
               rsp_a_d   = bus.outA;
               rsp_b_d   = bus.outB;
               rsp_err_d = OFF;
               state_d   = ST_RESP;
            end else if (tmr_zero) begin
               rsp_a_d   = '0;
               rsp_b_d   = '0;
               rsp_err_d = ON;
               state_d   = ST_RESP;
            end else begin
               tmr_dec = ON;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         rsp_a_q   <= '0;
         rsp_b_q   <= '0;
         rsp_err_q <= OFF;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         rsp_a_q   <= rsp_a_d;
         rsp_b_q   <= rsp_b_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   // Outputs decode straight from the async-reset state so reset drops start without a clock.
   assign busy = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_WAIT);

   assign bus.cmd_ready     = (state_q == ST_IDLE);
   assign bus.start         = (state_q == ST_STROBE);
   assign bus.read_addr_s   = cmd_q.rs;
   assign bus.read_addr_t   = cmd_q.rt;
   assign bus.write_addr    = cmd_q.wr_addr;
   assign bus.write_enabled = cmd_q.wr_en & busy;
   assign bus.write_data    = cmd_q.wr_data;
   assign bus.rsp_valid     = (state_q == ST_RESP);
   assign bus.rsp_a         = rsp_a_q;
   assign bus.rsp_b         = rsp_b_q;
   assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_rf_32_requester.sv
// Randomized bench for rf_32_requester against a transaction-level register model.
module tb_rf_32_requester;
   import rf_pkg::*;

   localparam int S = 2;
   localparam int T = 15;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rf_32_requester_if bus ();

   rf_32_requester #(.STROBE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rf_mem   [32];
   logic [31:0] ref_regs [32];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic run_txn(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                          input logic we, input logic [31:0] wd, input bit respond, input int hold);
      logic [31:0] exp_a, exp_b, snap_a, snap_b;
      logic        exp_err;
      int          k, k_start, n_start, k_rsp, bad_rf, bad_ready, bad_hold, wait_cnt;
      bit          seen_strobe;

      exp_a   = respond ? ref_regs[rs] : 32'h0;
      exp_b   = respond ? ref_regs[rt] : 32'h0;
      exp_err = !respond;
      if (respond && we && (wa != 5'd0)) ref_regs[wa] = wd;

      k = 0; k_start = -1; n_start = 0; k_rsp = -1;
      bad_rf = 0; bad_ready = 0; bad_hold = 0; wait_cnt = 0; seen_strobe = 0;
      snap_a = '0; snap_b = '0;

      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_rs      = rs;
      bus.cmd_rt      = rt;
      bus.cmd_wr_addr = wa;
      bus.cmd_wr_en   = we;
      bus.cmd_wr_data = wd;
      if (!respond) begin
         bus.outA = $urandom;
         bus.outB = $urandom;
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;

      while (k_rsp < 0 && k < 40) begin
         if (bus.rsp_valid) begin
            k_rsp = k;
         end else begin
            if (bus.read_addr_s !== rs || bus.read_addr_t !== rt || bus.write_addr !== wa ||
                bus.write_data !== wd || bus.write_enabled !== we) bad_rf++;
            if (bus.cmd_ready) bad_ready++;
            if (bus.start) begin
               if (k_start < 0) begin
                  k_start = k;
                  snap_a  = rf_mem[bus.read_addr_s];
                  snap_b  = rf_mem[bus.read_addr_t];
               end
               n_start++;
               seen_strobe = 1'b1;
            end else if (seen_strobe && respond) begin
               wait_cnt++;
               if (wait_cnt == 2) begin
                  bus.finish = 1'b1;
                  bus.outA   = snap_a;
                  bus.outB   = snap_b;
                  if (bus.write_enabled && bus.write_addr != 5'd0)
                     rf_mem[bus.write_addr] = bus.write_data;
               end
            end
            @(negedge clk);
            k++;
         end
      end

      if (k_rsp < 0) begin
         check("rsp_valid_bound", 64'(0), 64'(1));
         bus.finish = 1'b0;
         return;
      end

      check("start_first_cycle", 64'(k_start), 64'(1));
      check("start_len", 64'(n_start), 64'(S));
      check("rsp_latency", 64'(k_rsp), respond ? 64'(1 + S + 2) : 64'(1 + S + T));
      check("rf_ports_stable", 64'(bad_rf), 64'(0));
      check("busy_cmd_ready", 64'(bad_ready), 64'(0));
      check("rsp_a", 64'(bus.rsp_a), 64'(exp_a));
      check("rsp_b", 64'(bus.rsp_b), 64'(exp_b));
      check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));

      bus.finish = 1'b0;
      if (hold > 0) begin
         bus.cmd_valid   = 1'b1;
         bus.cmd_rs      = 5'($urandom);
         bus.cmd_wr_data = $urandom;
      end
      for (int i = 0; i < hold; i++) begin
         bus.outA = $urandom;
         bus.outB = $urandom;
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_a !== exp_a || bus.rsp_b !== exp_b ||
             bus.rsp_err !== exp_err || bus.cmd_ready) bad_hold++;
      end
      if (hold > 0) check("resp_hold", 64'(bad_hold), 64'(0));

      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("resp_release", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
   endtask

   task automatic reset_mid_strobe();
      int bad;
      bit seen;
      bad = 0; seen = 1'b0;
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_rs      = 5'd3;
      bus.cmd_rt      = 5'd4;
      bus.cmd_wr_addr = 5'd7;
      bus.cmd_wr_en   = 1'b1;
      bus.cmd_wr_data = 32'hA5A5_0001;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = bus.start;
      end
      check("reached_strobe", 64'(seen), 64'(1));
      #2 reset = 1'b1;
      #1;
      check("rst_start_async", 64'(bus.start), 64'(0));
      check("rst_ready_async", 64'(bus.cmd_ready), 64'(1));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.rsp_valid || !bus.cmd_ready) bad++;
      end
      check("rst_no_response", 64'(bad), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      reset           = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_rs      = '0;
      bus.cmd_rt      = '0;
      bus.cmd_wr_addr = '0;
      bus.cmd_wr_en   = 1'b0;
      bus.cmd_wr_data = '0;
      bus.finish      = 1'b0;
      bus.outA        = '0;
      bus.outB        = '0;
      bus.rsp_ready   = 1'b0;

      rf_mem[0] = '0;
      ref_regs[0] = '0;
      for (int i = 1; i < 32; i++) begin
         v = $urandom;
         rf_mem[i]   = v;
         ref_regs[i] = v;
      end

      #3;
      check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
      check("rst_start_we", 64'({bus.start, bus.write_enabled}), 64'(0));
      check("rst_addrs", 64'({bus.read_addr_s, bus.read_addr_t, bus.write_addr}), 64'(0));
      check("rst_write_data", 64'(bus.write_data), 64'(0));
      check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err}), 64'(0));
      check("rst_rsp_data", {bus.rsp_a, bus.rsp_b}, 64'(0));

      repeat (2) @(negedge clk);
      reset = 1'b0;

      run_txn(5'd5, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b1, 0);
      run_txn(5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 0);
      check("r5_readback_model", 64'(ref_regs[5]), 64'(32'hDEAD_BEEF));

      run_txn(5'd0, 5'd0, 5'd0, 1'b1, 32'h1234_5678, 1'b1, 0);
      run_txn(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b1, 0);

      run_txn(5'd9, 5'd10, 5'd11, 1'b1, 32'h0BAD_F00D, 1'b0, 2);
      run_txn(5'd12, 5'd13, 5'd12, 1'b1, 32'hCAFE_0012, 1'b1, 10);
      run_txn(5'd12, 5'd11, 5'd0, 1'b0, 32'h0, 1'b1, 0);

      reset_mid_strobe();

      for (int n = 0; n < 20; n++) begin
         run_txn(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                 $urandom, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
